// File: rtl/dmem_router.sv
// ---------------------------------------------------------------------------
// dmem_router
//
// Routes the CPU data-memory port to NUM_PORTS slave ports. The slave is
// chosen by an address field. Accepted transactions are recorded in an
// in-order target FIFO. Each response is therefore steered from the slave
// that owns the oldest request, even after the master has moved on.
// Addresses that decode beyond NUM_PORTS go to an internal pseudo-target.
// That target answers one cycle after acceptance with data 0, so the
// master never hangs.
//
// Optional feature macro: DMEM_ROUTER_ERR_EN
//   When defined, mem_err_o pulses with every unmapped response.
//   err_addr_o holds the address of the first unmapped access seen since
//   reset.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   mem_addr_i          master address
//   mem_data_i          master write data
//   mem_wr_i            master byte write enables
//   mem_rd_i            master read request
//   mem_burst_i         master burst hint
//   mem_data_o          read data returned to the master
//   mem_ack_o           response strobe to the master
//   mem_accept_o        request accepted this cycle
//   out_addr_o          per-slave address, slot k = bits [32k+31:32k]
//   out_data_o          per-slave write data, same packing
//   out_wr_o            per-slave byte enables, slot k = bits [4k+3:4k]
//   out_rd_o            per-slave read request
//   out_burst_o         per-slave burst hint
//   out_data_i          per-slave read data, same packing as out_data_o
//   out_ack_i           per-slave response strobe
//   out_accept_i        per-slave accept
//   mem_err_o           unmapped-response strobe (DMEM_ROUTER_ERR_EN only)
//   err_addr_o          first unmapped address (DMEM_ROUTER_ERR_EN only)
// ---------------------------------------------------------------------------
module dmem_router #(
    parameter int NUM_PORTS       = 3,
    parameter int ADDR_MUX_START  = 28,
    parameter int ADDR_MUX_BITS   = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              mem_addr_i,
    input  logic [31:0]              mem_data_i,
    input  logic [3:0]               mem_wr_i,
    input  logic                     mem_rd_i,
    input  logic                     mem_burst_i,
    output logic [31:0]              mem_data_o,
    output logic                     mem_ack_o,
    output logic                     mem_accept_o,
    output logic [32*NUM_PORTS-1:0]  out_addr_o,
    output logic [32*NUM_PORTS-1:0]  out_data_o,
    output logic [4*NUM_PORTS-1:0]   out_wr_o,
    output logic [NUM_PORTS-1:0]     out_rd_o,
    output logic [NUM_PORTS-1:0]     out_burst_o,
    input  logic [32*NUM_PORTS-1:0]  out_data_i,
    input  logic [NUM_PORTS-1:0]     out_ack_i,
`ifdef DMEM_ROUTER_ERR_EN
    input  logic [NUM_PORTS-1:0]     out_accept_i,
    output logic                     mem_err_o,
    output logic [31:0]              err_addr_o
`else
    input  logic [NUM_PORTS-1:0]     out_accept_i
`endif
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_OUTSTANDING);

    logic [ADDR_MUX_BITS-1:0] sel;
    logic                     sel_unmapped;
    logic                     req;
    logic                     sel_accept;
    logic                     full_block;
    logic                     target_differs;
    logic                     unmapped_block;
    logic                     stall;
    logic                     fwd;
    logic                     accept;
    logic                     pop;
    logic                     empty;

    logic [ADDR_MUX_BITS-1:0] fifo_sel [MAX_OUTSTANDING];
    logic                     fifo_unmapped [MAX_OUTSTANDING];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         count;

    logic [ADDR_MUX_BITS-1:0] last_sel;
    logic                     last_unmapped;
    logic                     u_ack;

    logic [ADDR_MUX_BITS-1:0] head_sel;
    logic                     head_unmapped;
    logic                     head_slave_ack;
    logic [31:0]              head_slave_data;
    logic                     head_ack;

    assign sel          = mem_addr_i[ADDR_MUX_START +: ADDR_MUX_BITS];
    assign sel_unmapped = (int'(sel) >= NUM_PORTS);
    assign req          = mem_rd_i | (|mem_wr_i);
    assign empty        = (count == '0);

    assign head_sel      = fifo_sel[rd_ptr];
    assign head_unmapped = fifo_unmapped[rd_ptr];

    // Responses come from the owner of the oldest outstanding request.
    // Slave acks arriving with nothing outstanding are dropped. This covers
    // stray acks and acks left over from before a reset.
    always_comb begin
        head_slave_ack  = 1'b0;
        head_slave_data = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (int'(head_sel) == k) begin
                head_slave_ack  = out_ack_i[k];
                head_slave_data = out_data_i[32*k +: 32];
            end
        end
    end

    assign head_ack   = head_unmapped ? u_ack : head_slave_ack;
    assign pop        = ~rst_i & ~empty & head_ack;
    assign mem_ack_o  = pop;
    assign mem_data_o = (rst_i | empty | head_unmapped) ? 32'h0 : head_slave_data;

    // A full FIFO may still accept when the head retires this same cycle.
    // That keeps one-per-cycle throughput to a busy slave.
    // Changing target (or going to the unmapped target) waits until the FIFO
    // is completely empty, so responses can never overtake each other.
    assign full_block     = (count == FULL_COUNT) & ~pop;
    assign target_differs = ~empty & (sel_unmapped | last_unmapped | (sel != last_sel));
    assign unmapped_block = ~empty & sel_unmapped;
    assign stall          = full_block | target_differs | unmapped_block;
    assign fwd            = req & ~stall & ~rst_i;
    assign accept         = fwd & (sel_unmapped | sel_accept);
    assign mem_accept_o   = accept;

    // The selected slot always sees address, data and burst. The read and
    // write strobes only reach a slave when the request may really issue.
    always_comb begin
        out_addr_o  = '0;
        out_data_o  = '0;
        out_wr_o    = '0;
        out_rd_o    = '0;
        out_burst_o = '0;
        sel_accept  = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!sel_unmapped && int'(sel) == k) begin
                out_addr_o[32*k +: 32] = mem_addr_i;
                out_data_o[32*k +: 32] = mem_data_i;
                out_burst_o[k]         = mem_burst_i;
                sel_accept             = out_accept_i[k];
                if (fwd) begin
                    out_rd_o[k]        = mem_rd_i;
                    out_wr_o[4*k +: 4] = mem_wr_i;
                end
            end
        end
    end

    // FIFO bookkeeping. The newest target is kept in its own register so the
    // ordering check does not need to read the FIFO at wr_ptr-1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            u_ack         <= 1'b0;
            last_sel      <= '0;
            last_unmapped <= 1'b0;
        end else begin
            u_ack <= accept & sel_unmapped;
            if (accept) begin
                wr_ptr        <= wr_ptr + 1'b1;
                last_sel      <= sel;
                last_unmapped <= sel_unmapped;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage needs no reset; the entries are only read while count > 0.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_sel[wr_ptr]      <= sel;
            fifo_unmapped[wr_ptr] <= sel_unmapped;
        end
    end

`ifdef DMEM_ROUTER_ERR_EN
    logic        err_seen;
    logic [31:0] err_addr;

    // The first unmapped address is captured once and held until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_seen <= 1'b0;
            err_addr <= '0;
        end else if (accept && sel_unmapped && !err_seen) begin
            err_seen <= 1'b1;
            err_addr <= mem_addr_i;
        end
    end

    assign mem_err_o  = pop & head_unmapped;
    assign err_addr_o = rst_i ? 32'h0 : err_addr;
`endif

endmodule
